// File: rtl/par_link_tx.sv
// par_link_tx: four-phase parallel link transmitter draining an upstream FIFO with parity, timeout and transfer count
module par_link_tx #(
  parameter int DATA_W = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic              link_ack,
  output logic [DATA_W-1:0] link_data,
  output logic              link_parity,
  output logic              link_req,
  output logic              busy,
  output logic              timeout_err,
  output logic [15:0]       word_count
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, POP, LOAD, REQ_HI, REQ_LO} state_t;
  state_t state, state_n;
  logic ack_m, ack_s, waiting, expired, abort, done;
  logic [CW-1:0] wait_cnt;
  assign waiting = (state == REQ_HI && !ack_s) || (state == REQ_LO && ack_s);
  assign expired = wait_cnt == CW'(TIMEOUT);
  assign abort = waiting && expired;
  assign done = state == REQ_LO && !ack_s;
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= link_ack;
      ack_s <= ack_m;
    end
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = fifo_rd_en ? POP : IDLE;
      POP:     state_n = LOAD;
      LOAD:    state_n = REQ_HI;
      REQ_HI:  state_n = ack_s ? REQ_LO : (expired ? IDLE : REQ_HI);
      REQ_LO:  state_n = (done || expired) ? IDLE : REQ_LO;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    fifo_rd_en = !reset && state == IDLE && !fifo_empty && !ack_s;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      link_req <= 1'b0;
      wait_cnt <= '0;
      timeout_err <= 1'b0;
      word_count <= '0;
      link_data <= '0;
      link_parity <= 1'b0;
    end else begin
      link_req <= state_n == REQ_HI;
      wait_cnt <= (waiting && state_n == state) ? wait_cnt + CW'(1) : '0;
      if (abort) timeout_err <= 1'b1;
      if (done) word_count <= word_count + 16'd1;
      if (state == LOAD) begin
        link_data <= fifo_data;
        link_parity <= ^fifo_data;
      end
    end
  end
endmodule

// File: tb/tb_par_link_tx.sv
// tb_par_link_tx: scoreboard bench for par_link_tx with a FIFO model and a remote that acks 3 cycles after each req edge
module tb_par_link_tx;
  localparam int TMO = 15;
  typedef struct packed {logic [15:0] d; logic p;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] fifo_data = '0;
  logic fifo_empty, fifo_rd_en, link_ack, link_parity, link_req, busy, timeout_err;
  logic [15:0] link_data, word_count;
  logic [15:0] mem [0:63];
  logic [15:0] d1 = '0;
  logic [2:0] req_hist = '0;
  int wp = 0, rp = 0, mode = 0;
  int errs = 0, checks = 0, pops = 0, req_cycles = 0, cyc = 0, last_pop = -100;
  exp_t sb[$];
  par_link_tx #(.DATA_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .link_ack(link_ack), .link_data(link_data),
    .link_parity(link_parity), .link_req(link_req), .busy(busy),
    .timeout_err(timeout_err), .word_count(word_count)
  );
  always #5 clk = ~clk;
  assign fifo_empty = wp == rp;
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      d1 <= mem[rp[5:0]];
      rp <= rp + 1;
    end
    fifo_data <= d1;
  end
  always @(posedge clk) req_hist <= {req_hist[1:0], link_req};
  assign link_ack = (mode == 0) ? req_hist[2] : (mode == 2);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [15:0] d, input logic p);
    mem[wp[5:0]] = d;
    wp++;
    sb.push_back('{d, p});
  endtask
  initial begin
    logic prev_req;
    logic [15:0] held;
    exp_t cur;
    prev_req = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (fifo_rd_en) begin
        pops++;
        chk("pop_legal", 32'(!fifo_empty && !busy && (cyc - last_pop >= 6)), 32'd1);
        last_pop = cyc;
      end
      if (link_req && !prev_req) begin
        if (sb.size() == 0) chk("req_without_word", 32'(link_data), 32'hFFFF_FFFF);
        else begin
          cur = sb.pop_front();
          chk("link_data", 32'(link_data), 32'(cur.d));
          chk("link_parity", 32'(link_parity), 32'(cur.p));
          held = link_data;
        end
      end else if (link_req) chk("data_stable", 32'(link_data), 32'(held));
      if (link_req) req_cycles++;
      prev_req = link_req;
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [15:0] pmask;
    int n, r0;
    pmask = 16'hB4CB;
    step(4);
    chk("rst_link_req", 32'(link_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_link_data", 32'(link_data), 0);
    chk("rst_parity", 32'(link_parity), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    chk("rst_count", 32'(word_count), 0);
    reset = 1'b0;
    step(2);
    push(16'h1234, 1'b1);
    n = 0;
    while (word_count != 16'd1 && n < 300) begin step(1); n++; end
    chk("single_count", 32'(word_count), 1);
    chk("single_busy", 32'(busy), 0);
    chk("single_pops", 32'(pops), 1);
    chk("single_data", 32'(link_data), 32'h1234);
    chk("single_parity", 32'(link_parity), 1);
    for (int i = 1; i <= 16; i++) push(16'(i), pmask[i-1]);
    n = 0;
    while (word_count != 16'd17 && n < 2000) begin step(1); n++; end
    chk("burst_count", 32'(word_count), 17);
    chk("burst_pops", 32'(pops), 17);
    chk("burst_drained", 32'(sb.size()), 0);
    chk("burst_last_data", 32'(link_data), 32'h0010);
    mode = 2;
    step(6);
    push(16'hA5A5, 1'b0);
    step(40);
    chk("stuck_no_pop", 32'(pops), 17);
    chk("stuck_idle", 32'(busy), 0);
    mode = 0;
    n = 0;
    while (word_count != 16'd18 && n < 300) begin step(1); n++; end
    chk("stuck_release_count", 32'(word_count), 18);
    mode = 1;
    step(6);
    r0 = req_cycles;
    push(16'h00FF, 1'b0);
    n = 0;
    while (!timeout_err && n < 200) begin step(1); n++; end
    step(2);
    chk("tmo_flag", 32'(timeout_err), 1);
    chk("tmo_req_low", 32'(link_req), 0);
    chk("tmo_count", 32'(word_count), 18);
    chk("tmo_idle", 32'(busy), 0);
    chk("tmo_req_cycles", 32'(req_cycles - r0 >= TMO && req_cycles - r0 <= TMO + 1), 1);
    mode = 0;
    step(10);
    chk("tmo_sticky", 32'(timeout_err), 1);
    push(16'h5A5A, 1'b0);
    n = 0;
    while (!link_req && n < 100) begin step(1); n++; end
    chk("mid_req_seen", 32'(link_req), 1);
    step(2);
    reset = 1'b1;
    step(1);
    chk("mid_link_req", 32'(link_req), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_rd_en", 32'(fifo_rd_en), 0);
    chk("mid_link_data", 32'(link_data), 0);
    chk("mid_parity", 32'(link_parity), 0);
    chk("mid_timeout", 32'(timeout_err), 0);
    chk("mid_count", 32'(word_count), 0);
    reset = 1'b0;
    step(10);
    force dut.word_count = 16'hFFFF;
    step(1);
    release dut.word_count;
    push(16'h8001, 1'b0);
    n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin step(1); n++; end
    step(2);
    chk("wrap_count", 32'(word_count), 0);
    chk("wrap_idle", 32'(busy), 0);
    chk("final_timeout", 32'(timeout_err), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
